// File: rtl/uart_word_tx.sv
// uart_word_tx: serialises one N_BITS sample word per accepted start as N_BITS/8
// consecutive 8N1 UART frames, least-significant byte first, with no gap between
// frames. A word is accepted from IDLE, or from the single DONE cycle so that
// words can be sent back to back.
//
// Ports:
//   clk            system clock; all logic on the rising edge
//   rst            asynchronous reset, active low
//   in_tx_start    request to load in_tx_data and transmit it
//   in_tx_data     sample word; sampled only on the accepting edge
//   out_tx_active  high while the word's frames are on the line
//   out_tx_serial  UART TX line, idle high
//   out_tx_done    one-cycle pulse after the final stop bit of the word
//
// All outputs are registered. The output registers are loaded from the next
// state, so each output reflects the state the FSM has just entered.
module uart_word_tx #(
  parameter int unsigned N_BITS       = 32,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_tx_start,
  input  logic [N_BITS-1:0] in_tx_data,
  output logic              out_tx_active,
  output logic              out_tx_serial,
  output logic              out_tx_done
);

  localparam int unsigned N_BYTES = N_BITS / 8;
  localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int unsigned BYTE_W  = $clog2(N_BYTES) + 1;

  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(N_BYTES - 1);
  localparam logic [2:0]        LAST_BIT  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_BIT,
    S_DATA_BITS,
    S_STOP_BIT,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    clk_cnt_q, clk_cnt_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0]   byte_idx_q, byte_idx_d;
  logic [N_BITS-1:0]   shift_q, shift_d;
  logic                serial_q, serial_d;
  logic                active_q, active_d;
  logic                done_q, done_d;
  logic                bit_end;
  logic [7:0]          cur_byte;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      serial_q   <= serial_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  // Next-state, counters and next output values
  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    serial_d   = 1'b1;
    active_d   = 1'b0;
    done_d     = 1'b0;
    cur_byte   = '0;
    bit_end    = (clk_cnt_q == LAST_CNT);

    case (state_q)
      // DONE behaves like IDLE for acceptance, giving back-to-back words
      S_IDLE, S_DONE: begin
        clk_cnt_d = '0;
        if (in_tx_start) begin
          state_d    = S_START_BIT;
          shift_d    = in_tx_data;
          byte_idx_d = '0;
          bit_idx_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_START_BIT: begin
        if (bit_end) begin
          state_d   = S_DATA_BITS;
          clk_cnt_d = '0;
          bit_idx_d = '0;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      S_DATA_BITS: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_idx_q == LAST_BIT) begin
            state_d = S_STOP_BIT;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      // Next byte's start bit follows the stop bit directly
      S_STOP_BIT: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (byte_idx_q < LAST_BYTE) begin
            state_d    = S_START_BIT;
            byte_idx_d = byte_idx_q + BYTE_W'(1);
            shift_d    = shift_q >> 8;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = S_IDLE;
        clk_cnt_d = '0;
      end
    endcase

    // Outputs for the state being entered; the line changes on the same edge
    cur_byte = shift_d[7:0];
    case (state_d)
      S_START_BIT: begin
        serial_d = 1'b0;
        active_d = 1'b1;
      end
      S_DATA_BITS: begin
        serial_d = cur_byte[bit_idx_d];
        active_d = 1'b1;
      end
      S_STOP_BIT: begin
        active_d = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        serial_d = 1'b1;
      end
    endcase
  end

  assign out_tx_active = active_q;
  assign out_tx_serial = serial_q;
  assign out_tx_done   = done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: two instances (32-bit/4 clk per bit and 8-bit/2 clk per bit).
// Drivers push expected bytes into queues when the reference model accepts a
// start; a UART receiver model on the line pops and compares each decoded byte.
module tb_uart_word_tx;

  localparam int unsigned NB0  = 32;
  localparam int unsigned CPB0 = 4;
  localparam int unsigned NB1  = 8;
  localparam int unsigned CPB1 = 2;
  localparam int WORD0 = (NB0 / 8) * 10 * CPB0;
  localparam int WORD1 = (NB1 / 8) * 10 * CPB1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st0 = 1'b0;
  logic [31:0] dt0 = '0;
  logic        act0, ser0, dn0;
  logic        st1 = 1'b0;
  logic [7:0]  dt1 = '0;
  logic        act1, ser1, dn1;

  always #5 clk = ~clk;

  uart_word_tx #(.N_BITS(NB0), .CLKS_PER_BIT(CPB0)) dut (
    .clk(clk), .rst(rst), .in_tx_start(st0), .in_tx_data(dt0),
    .out_tx_active(act0), .out_tx_serial(ser0), .out_tx_done(dn0)
  );

  uart_word_tx #(.N_BITS(NB1), .CLKS_PER_BIT(CPB1)) dut8 (
    .clk(clk), .rst(rst), .in_tx_start(st1), .in_tx_data(dt1),
    .out_tx_active(act1), .out_tx_serial(ser1), .out_tx_done(dn1)
  );

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Reference-model state
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int  last_acc[2];
  bit  ever_acc[2];
  int  exp_done[2];
  int  done_seen[2];

  // Receiver/monitor state
  bit         rx_busy[2];
  int         rx_cnt[2];
  logic [7:0] rx_sh[2];
  int         run[2];
  logic       pa[2];
  logic       pd[2];

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endfunction

  task automatic mon_step(input int id, input int cpb, input int wcyc,
                          input logic ser, input logic act, input logic dn);
    int b;
    if (!rst) begin
      chk("rst_serial", 32'(ser), 32'd1);
      chk("rst_active", 32'(act), 32'd0);
      chk("rst_done", 32'(dn), 32'd0);
      rx_busy[id] = 1'b0;
      run[id] = 0;
      pa[id] = 1'b0;
      pd[id] = 1'b0;
      return;
    end
    if (act) run[id]++;
    if (pa[id] && !act) begin
      chk("active_len", 32'(run[id]), 32'(wcyc));
      run[id] = 0;
    end
    if (dn) begin
      done_seen[id]++;
      chk("done_after_active", 32'(pa[id]), 32'd1);
      chk("done_width", 32'(pd[id]), 32'd0);
    end
    if (!act) chk("idle_serial", 32'(ser), 32'd1);
    pa[id] = act;
    pd[id] = dn;
    if (!rx_busy[id]) begin
      if (ser == 1'b0) begin
        rx_busy[id] = 1'b1;
        rx_cnt[id] = 0;
      end
    end else begin
      rx_cnt[id]++;
      if (rx_cnt[id] == cpb / 2) begin
        chk("start_bit", 32'(ser), 32'd0);
      end else if (rx_cnt[id] > cpb && rx_cnt[id] < 9 * cpb && (rx_cnt[id] % cpb) == cpb / 2) begin
        b = rx_cnt[id] / cpb - 1;
        rx_sh[id][b] = ser;
      end else if (rx_cnt[id] == 9 * cpb + cpb / 2) begin
        chk("stop_bit", 32'(ser), 32'd1);
        rx_busy[id] = 1'b0;
        if (id == 0) begin
          if (q0.size() == 0) chk("unexpected_byte0", 32'(rx_sh[0]), 32'hFFFF_FFFF);
          else chk("byte0", 32'(rx_sh[0]), 32'(q0.pop_front()));
        end else begin
          if (q1.size() == 0) chk("unexpected_byte1", 32'(rx_sh[1]), 32'hFFFF_FFFF);
          else chk("byte1", 32'(rx_sh[1]), 32'(q1.pop_front()));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, CPB0, WORD0, ser0, act0, dn0);
    mon_step(1, CPB1, WORD1, ser1, act1, dn1);
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      dt0 = $urandom;
      dt1 = 8'($urandom);
    end
  endtask

  // Present one start pulse; the model decides acceptance from elapsed time
  task automatic start_word(input int id, input logic [31:0] data);
    int nb;
    int w;
    bit acc;
    logic [31:0] d;
    nb = (id == 0) ? int'(NB0 / 8) : int'(NB1 / 8);
    w  = (id == 0) ? WORD0 : WORD1;
    d  = (id == 0) ? data : {24'd0, data[7:0]};
    acc = !ever_acc[id] || ((edge_n + 1 - last_acc[id]) >= w + 1);
    if (id == 0) begin
      st0 = 1'b1; dt0 = d;
    end else begin
      st1 = 1'b1; dt1 = d[7:0];
    end
    if (acc) begin
      for (int k = 0; k < nb; k++) begin
        if (id == 0) q0.push_back(8'(d >> (8 * k)));
        else q1.push_back(8'(d >> (8 * k)));
      end
      last_acc[id] = edge_n + 1;
      ever_acc[id] = 1'b1;
      exp_done[id]++;
    end
    @(negedge clk);
    if (id == 0) st0 = 1'b0; else st1 = 1'b0;
    dt0 = $urandom;
    dt1 = 8'($urandom);
  endtask

  task automatic wait_word_end(input int id);
    int w;
    w = (id == 0) ? WORD0 : WORD1;
    for (int i = 0; i < 5000; i++) begin
      if (!ever_acc[id] || (edge_n - last_acc[id]) >= w + 1) break;
      idle_cycles(1);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      last_acc[i] = 0; ever_acc[i] = 1'b0; exp_done[i] = 0; done_seen[i] = 0;
      rx_busy[i] = 1'b0; rx_cnt[i] = 0; rx_sh[i] = '0; run[i] = 0; pa[i] = 1'b0; pd[i] = 1'b0;
    end

    // Held in reset while inputs toggle
    repeat (20) begin
      @(negedge clk);
      st0 = 1'($urandom); dt0 = $urandom;
      st1 = 1'($urandom); dt1 = 8'($urandom);
    end
    @(negedge clk);
    st0 = 1'b0; st1 = 1'b0;
    #2 rst = 1'b1;
    idle_cycles(3);

    // Directed word
    start_word(0, 32'hA5C30F81);
    wait_word_end(0);
    idle_cycles(4);

    // Start during byte 1 is ignored
    start_word(0, 32'h12345678);
    idle_cycles(55);
    start_word(0, 32'hFFFFFFFF);
    wait_word_end(0);
    idle_cycles(3);

    // Start in the DONE cycle is accepted immediately
    start_word(0, $urandom);
    for (int i = 0; i < 400; i++) begin
      idle_cycles(1);
      if (dn0) break;
    end
    chk("done_before_b2b", 32'(dn0), 32'd1);
    start_word(0, 32'h00000001);
    chk("b2b_active", 32'(act0), 32'd1);
    chk("b2b_serial", 32'(ser0), 32'd0);
    wait_word_end(0);
    idle_cycles(3);

    // Asynchronous reset during byte 2 data bits
    start_word(0, $urandom);
    idle_cycles(88);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_serial", 32'(ser0), 32'd1);
    chk("async_rst_active", 32'(act0), 32'd0);
    chk("async_rst_done", 32'(dn0), 32'd0);
    q0.delete();
    q1.delete();
    if (ever_acc[0] && (edge_n - last_acc[0]) < WORD0) exp_done[0]--;
    ever_acc[0] = 1'b0;
    ever_acc[1] = 1'b0;
    idle_cycles(5);
    #2 rst = 1'b1;
    idle_cycles(2);
    start_word(0, 32'h000000AA);
    wait_word_end(0);
    idle_cycles(2);

    // Random words with random spurious restarts
    for (int n = 0; n < 6; n++) begin
      start_word(0, $urandom);
      idle_cycles(int'($urandom_range(10, 175)));
      start_word(0, $urandom);
      wait_word_end(0);
      idle_cycles(int'($urandom_range(0, 3)));
    end

    // Single-byte instance
    start_word(1, 32'h0000003C);
    wait_word_end(1);
    for (int n = 0; n < 8; n++) begin
      start_word(1, $urandom);
      idle_cycles(int'($urandom_range(0, 25)));
    end
    wait_word_end(1);
    wait_word_end(0);
    idle_cycles(6);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("done_count0", 32'(done_seen[0]), 32'(exp_done[0]));
    chk("done_count1", 32'(done_seen[1]), 32'(exp_done[1]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
